// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Definitions shared by the convolution accelerator, the requantizer and the
// writeback stage: datapath widths, the default beat geometry, packed beat
// typedefs and the int8 saturation helper.
//
// Beat layout: element e = px*OC_PAR + oc sits at index e of the packed
// vector (element 0 in the least significant bits).
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int PP_PAR      = 8;
  localparam int OC_PAR      = 16;
  localparam int ACC_WIDTH   = 28;
  localparam int OUT_WIDTH   = 8;
  localparam int BIAS_WIDTH  = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int PROD_WIDTH  = 48;
  localparam int SHIFT_WIDTH = 6;

  typedef logic [PP_PAR*OC_PAR-1:0][ACC_WIDTH-1:0] acc_vec_t;
  typedef logic [PP_PAR*OC_PAR-1:0][OUT_WIDTH-1:0] out_vec_t;

  // Clamp a rounded product (one guard bit above PROD_WIDTH) into the
  // signed OUT_WIDTH range.
  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [PROD_WIDTH:0] x
  );
    if (x > $signed({{(PROD_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}}))
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (x < $signed({{(PROD_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}}))
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      return x[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/conv_sync_fifo.sv
// -----------------------------------------------------------------------------
// conv_sync_fifo
// Single-clock FIFO, parameterized width and depth (DEPTH a power of two,
// >= 2). A push into a full FIFO is accepted when a pop happens in the same
// cycle; a pop of an empty FIFO is ignored.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (pointers and count)
//   i_push   write request, i_wdata written when accepted
//   i_pop    read request, o_rdata is the current head (show-ahead)
//   o_count  occupancy, 0..DEPTH
//   o_full   occupancy == DEPTH
//   o_empty  occupancy == 0
// -----------------------------------------------------------------------------
module conv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // NOTE: the storage array is deliberately left out of reset; the count
  // gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_requantizer.sv
// -----------------------------------------------------------------------------
// conv_requantizer
// Output stage of the convolution accelerator. Accumulator beats arrive
// without back-pressure and are buffered in a small FIFO; a 3-stage pipeline
// then applies per-channel bias (S1), per-channel scale (S2) and a rounding
// right shift with optional ReLU and int8 saturation (S3). Results leave on a
// valid/ready stream. One global enable (adv) moves all stages together.
//
// Build option: define CONV_REQUANT_RELU_EN to clamp negative results to 0.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_data      PP_PAR*OC_PAR accumulators, element px*OC_PAR+oc
//   in_valid     beat present (dropped if the FIFO is full and not popping)
//   bias, scale  per-channel signed bias / unsigned multiplier
//   shift        rounding right-shift amount, 0..47
//   out_data     requantized beat, same element order as in_data
//   out_valid    out_data valid; held stable until out_ready
//   out_ready    downstream accepts
//   fifo_count   FIFO occupancy
//   overflow     sticky drop flag, cleared only by rst
//   busy         FIFO non-empty or any stage valid
// -----------------------------------------------------------------------------
module conv_requantizer #(
  parameter int PP_PAR     = conv_pkg::PP_PAR,
  parameter int OC_PAR     = conv_pkg::OC_PAR,
  parameter int ACC_WIDTH  = conv_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH  = conv_pkg::OUT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [PP_PAR*OC_PAR*ACC_WIDTH-1:0]        in_data,
  input  logic                                      in_valid,
  input  logic [OC_PAR*conv_pkg::BIAS_WIDTH-1:0]    bias,
  input  logic [OC_PAR*conv_pkg::SCALE_WIDTH-1:0]   scale,
  input  logic [conv_pkg::SHIFT_WIDTH-1:0]          shift,
  output logic [PP_PAR*OC_PAR*OUT_WIDTH-1:0]        out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [$clog2(FIFO_DEPTH):0]               fifo_count,
  output logic                                      overflow,
  output logic                                      busy
);

  import conv_pkg::*;

  localparam int NEL = PP_PAR * OC_PAR;

  logic [NEL*ACC_WIDTH-1:0]     w_head;
  logic                         w_empty;
  logic                         w_full;
  logic                         w_adv;
  logic                         w_pop;

  logic                         r_s1_valid;
  logic                         r_s2_valid;
  logic                         r_out_valid;
  logic                         r_overflow;

  logic signed [BIAS_WIDTH-1:0] w_b    [NEL];
  logic signed [BIAS_WIDTH-1:0] r_s1_b [NEL];
  logic signed [PROD_WIDTH-1:0] w_p    [NEL];
  logic signed [PROD_WIDTH-1:0] r_s2_p [NEL];
  logic signed [PROD_WIDTH:0]   w_sum  [NEL];
  logic signed [PROD_WIDTH:0]   w_r    [NEL];
  logic [PROD_WIDTH:0]          w_rnd;
  logic [NEL*OUT_WIDTH-1:0]     w_q;
  logic [NEL*OUT_WIDTH-1:0]     r_out_data;

  // The whole pipeline stalls as one unit: the output register is the only
  // place that can be blocked, and nothing downstream of the FIFO absorbs
  // extra beats.
  assign w_adv = !r_out_valid || out_ready;
  assign w_pop = w_adv && !w_empty;

  conv_sync_fifo #(
    .WIDTH (NEL*ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Half-LSB rounding constant; the sum carries one guard bit so adding it
  // to a near-full-scale product cannot wrap.
  assign w_rnd = (shift == '0) ? '0
               : ((PROD_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1)));

  for (genvar g = 0; g < NEL; g++) begin : g_lane
    localparam int OC = g % OC_PAR;

    assign w_b[g] = {{(BIAS_WIDTH-ACC_WIDTH){w_head[g*ACC_WIDTH+ACC_WIDTH-1]}},
                     w_head[g*ACC_WIDTH +: ACC_WIDTH]}
                  + bias[OC*BIAS_WIDTH +: BIAS_WIDTH];

    assign w_p[g] = $signed({{(PROD_WIDTH-BIAS_WIDTH){r_s1_b[g][BIAS_WIDTH-1]}}, r_s1_b[g]})
                  * $signed({{(PROD_WIDTH-SCALE_WIDTH){1'b0}}, scale[OC*SCALE_WIDTH +: SCALE_WIDTH]});

    assign w_sum[g] = $signed({r_s2_p[g][PROD_WIDTH-1], r_s2_p[g]}) + $signed(w_rnd);
    assign w_r[g]   = w_sum[g] >>> shift;

`ifdef CONV_REQUANT_RELU_EN
    assign w_q[g*OUT_WIDTH +: OUT_WIDTH] = saturate(w_r[g][PROD_WIDTH] ? '0 : w_r[g]);
`else
    assign w_q[g*OUT_WIDTH +: OUT_WIDTH] = saturate(w_r[g]);
`endif
  end

  // Datapath registers only load when a valid beat moves into them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NEL; i++) begin
      if (w_pop)                r_s1_b[i] <= w_b[i];
      if (w_adv && r_s1_valid)  r_s2_p[i] <= w_p[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (in_valid && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_adv) begin
        r_s1_valid  <= w_pop;
        r_s2_valid  <= r_s1_valid;
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) r_out_data <= w_q;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign busy      = !w_empty || r_s1_valid || r_s2_valid || r_out_valid;

endmodule

// File: tb/tb_conv_requantizer.sv
module tb_conv_requantizer;
  import conv_pkg::*;

  localparam int NEL = PP_PAR * OC_PAR;
  localparam int OV  = NEL * OUT_WIDTH;
`ifdef CONV_REQUANT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                            clk = 1'b0;
  logic                            rst;
  acc_vec_t                        in_data;
  logic                            in_valid;
  logic [OC_PAR*BIAS_WIDTH-1:0]    bias;
  logic [OC_PAR*SCALE_WIDTH-1:0]   scale;
  logic [SHIFT_WIDTH-1:0]          shift;
  out_vec_t                        out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [2:0]                      fifo_count;
  logic                            overflow;
  logic                            busy;

  int       n_cmp = 0;
  int       n_err = 0;
  out_vec_t exp_q [$];
  logic     stall_prev = 1'b0;
  out_vec_t held;
  out_vec_t ev;

  conv_requantizer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .bias       (bias),
    .scale      (scale),
    .shift      (shift),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OV-1:0] obs, input logic [OV-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic acc_vec_t acc_all(input int v);
    acc_vec_t r;
    for (int e = 0; e < NEL; e++) r[e] = ACC_WIDTH'(v);
    return r;
  endfunction

  function automatic out_vec_t out_all(input int v);
    out_vec_t r;
    for (int e = 0; e < NEL; e++) r[e] = OUT_WIDTH'(v);
    return r;
  endfunction

  task automatic set_cfg(input int b, input int s, input int sh);
    for (int oc = 0; oc < OC_PAR; oc++) begin
      bias[oc*BIAS_WIDTH +: BIAS_WIDTH]    = BIAS_WIDTH'(b);
      scale[oc*SCALE_WIDTH +: SCALE_WIDTH] = SCALE_WIDTH'(s);
    end
    shift = SHIFT_WIDTH'(sh);
  endtask

  // One clock: scoreboard any handshake about to happen, check hold
  // stability of a stalled output, then advance to 1 time unit past the edge.
  task automatic tick();
    if (stall_prev) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_hold", out_data, held);
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_beat: observed %0h required no beat", out_data);
      end
      if (exp_q.size() > 0) check("beat_data", out_data, exp_q.pop_front());
    end
    stall_prev = out_valid && !out_ready && !rst;
    held       = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() > 0 || busy); i++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic run_one(input int acc, input int exp);
    exp_q.push_back(out_all(exp));
    in_data  = acc_all(acc);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(20);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    set_cfg(0, 1, 0);
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single beat: (100+28)*3 = 384, (384+2)>>>2 = 96, visible after edge N+3.
    set_cfg(28, 3, 2);
    out_ready = 1'b1;
    exp_q.push_back(out_all(96));
    in_data = acc_all(100); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_fifo_count", fifo_count, 3'd1);
    check("lat_busy", busy, 1'b1);
    check("lat_n0_valid", out_valid, 1'b0);
    tick();
    check("lat_n1_valid", out_valid, 1'b0);
    check("lat_n1_fifo", fifo_count, 3'd0);
    tick();
    check("lat_n2_valid", out_valid, 1'b0);
    tick();
    check("lat_n3_valid", out_valid, 1'b1);
    check("lat_n3_data", out_data, out_all(96));
    drain(10);
    check("idle_busy", busy, 1'b0);

    // Saturation and rounding.
    set_cfg(0, 1, 0);
    run_one(10000, 127);
    run_one(-10000, RELU ? 0 : -128);
    run_one(127, 127);
    run_one(128, 127);
    run_one(-128, RELU ? 0 : -128);
    run_one(-129, RELU ? 0 : -128);
    run_one(50, 50);
    set_cfg(0, 1, 2);
    run_one(-6, RELU ? 0 : -1);
    set_cfg(0, 1, 1);
    run_one(5, 3);
    run_one(-5, RELU ? 0 : -2);
    // Full-scale product with maximum shift: b = 2^31-1, p ~ 0.99997*2^47 -> 1.
    set_cfg(2013265920, 65535, 47);
    run_one(134217727, 1);
    // b = -2^31, p = -2^47 + 2^31 -> rounds to -1.
    set_cfg(-2013265920, 65535, 47);
    run_one(-134217728, RELU ? 0 : -1);

    // Per-channel bias/scale and per-pixel accumulators.
    shift = '0;
    for (int oc = 0; oc < OC_PAR; oc++) begin
      bias[oc*BIAS_WIDTH +: BIAS_WIDTH]    = BIAS_WIDTH'(oc);
      scale[oc*SCALE_WIDTH +: SCALE_WIDTH] = SCALE_WIDTH'((oc % 2) + 1);
    end
    for (int px = 0; px < PP_PAR; px++)
      for (int oc = 0; oc < OC_PAR; oc++) begin
        in_data[px*OC_PAR+oc] = ACC_WIDTH'(px * 5);
        ev[px*OC_PAR+oc]      = OUT_WIDTH'((px * 5 + oc) * ((oc % 2) + 1));
      end
    exp_q.push_back(ev);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain(20);

    // Back-pressure: 10 back-to-back beats, out_ready low for 4 cycles.
    set_cfg(0, 1, 0);
    for (int t = 0; t < 14; t++) begin
      in_valid  = (t < 10);
      in_data   = acc_all(t + 20);
      out_ready = !(t >= 7 && t <= 10);
      if (t < 10) exp_q.push_back(out_all(t + 20));
      tick();
      if (t == 10) check("bp_fifo_full", fifo_count, 3'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_overflow", overflow, 1'b0);
    drain(30);
    check("bp_overflow_end", overflow, 1'b0);

    // Overflow: out_ready low for 8 cycles with continuous input.
    // Beats 0..2 fill the pipeline, 3..6 the FIFO, 7 is dropped.
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1;
      in_data  = acc_all(t + 40);
      if (t < 7) exp_q.push_back(out_all(t + 40));
      tick();
      if (t == 6) check("ovf_before_drop", overflow, 1'b0);
    end
    check("ovf_fifo_full", fifo_count, 3'd4);
    check("ovf_set", overflow, 1'b1);
    // Full FIFO with a pop in the same cycle accepts the write.
    out_ready = 1'b1;
    in_data   = acc_all(48);
    exp_q.push_back(out_all(48));
    tick();
    in_valid = 1'b0;
    check("ovf_push_pop", fifo_count, 3'd4);
    drain(30);
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-stream with the FIFO half full.
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1;
      in_data  = acc_all(t + 60);
      tick();
    end
    in_valid = 1'b0;
    check("mid_fifo_half", fifo_count, 3'd2);
    check("mid_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_fifo", fifo_count, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    out_ready = 1'b1;
    run_one(9, 9);
    check("post_rst_overflow", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
